coolgirl_mmc3_irq: RTL and testbench

MMC3-compatible scanline IRQ generator for the CoolGirl multicart mapper layer. It decodes CPU writes to $C000-$FFFF and filters PPU A12. It counts filtered A12 rising edges once per scanline and drives the cartridge `irq` line that the top-level pin assignment exports. It is instantiated from the mapper include when MMC3-family mappers are selected, alongside the bank registers that feed `prg_base`/`chr_addr_mapped`.

---
 rtl/coolgirl_pkg.sv | 17 +
 rtl/coolgirl_a12_filter.sv | 53 +++++
 rtl/coolgirl_mmc3_irq.sv | 112 +++++++++++
 tb/tb_coolgirl_mmc3_irq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coolgirl_pkg.sv
// Shared constants for the CoolGirl MMC3-family IRQ block: register decode
// values, counter width and the legal range of the A12 low-time filter.
package coolgirl_pkg;

    localparam int IRQ_CNT_W   = 8;
    localparam int A12_LOW_MIN = 1;
    localparam int A12_LOW_MAX = 7;

    // Register select is {A13, A0} of a $C000-$FFFF write.
    typedef enum logic [1:0] {
        REG_LATCH   = 2'b00,  // $C000
        REG_RELOAD  = 2'b01,  // $C001
        REG_DISABLE = 2'b10,  // $E000
        REG_ENABLE  = 2'b11   // $E001
    } irq_reg_e;

endpackage

// File: rtl/coolgirl_a12_filter.sv
// PPU A12 synchronizer and low-time filter; flags one clock event per
// synchronized rise that follows A12_LOW_CYCLES consecutive low samples.
module coolgirl_a12_filter
    import coolgirl_pkg::*;
#(
    parameter int A12_LOW_CYCLES = 3
) (
    input  logic m2,
    input  logic reset_n,
    input  logic ppu_a12,
    output logic clk_event
);

    localparam logic [2:0] LOW_SAT = 3'(A12_LOW_CYCLES);

    generate
        if (A12_LOW_CYCLES < A12_LOW_MIN || A12_LOW_CYCLES > A12_LOW_MAX) begin : g_bad_param
            $error("A12_LOW_CYCLES out of range");
        end
    endgenerate

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [2:0] low_cnt_q, low_cnt_d;

    always_comb begin
        sync1_d   = ppu_a12;
        sync2_d   = sync1_q;
        low_cnt_d = low_cnt_q;
        if (sync2_q) begin
            low_cnt_d = 3'd0;
        end else if (low_cnt_q != LOW_SAT) begin
            low_cnt_d = low_cnt_q + 3'd1;
        end
    end

    // low_cnt only reaches LOW_SAT while the previous sample was low, so a
    // high sample with a saturated count is exactly a filtered 0->1 edge.
    assign clk_event = sync2_q & (low_cnt_q == LOW_SAT);

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            low_cnt_q <= 3'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            low_cnt_q <= low_cnt_d;
        end
    end

endmodule

// File: rtl/coolgirl_mmc3_irq.sv
// MMC3-compatible scanline IRQ: register decode, scanline counter and irq.
// Define COOLGIRL_MMC3_IRQ_REV_A_EN for rev A (NEC) hit rules; default is rev B.
module coolgirl_mmc3_irq
    import coolgirl_pkg::*;
#(
    parameter int A12_LOW_CYCLES = 3
) (
    input  logic                 m2,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 romsel,
    input  logic                 cpu_rw_in,
    input  logic [14:0]          cpu_addr_in,
    input  logic [7:0]           cpu_data_in,
    input  logic                 ppu_a12,
    output logic                 irq,
    output logic [IRQ_CNT_W-1:0] irq_counter
);

    logic                 clk_event;
    logic                 evt;
    logic                 wr;
    irq_reg_e             sel;
    logic                 wr_latch, wr_reload, wr_disable, wr_enable;
    logic                 reload_path;
    logic                 hit;
    logic [IRQ_CNT_W-1:0] next_cnt;

    logic [IRQ_CNT_W-1:0] latch_q, latch_d;
    logic [IRQ_CNT_W-1:0] counter_q, counter_d;
    logic                 reload_q, reload_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;

    logic                 unused_addr;
    assign unused_addr = ^cpu_addr_in[12:1];

    coolgirl_a12_filter #(
        .A12_LOW_CYCLES(A12_LOW_CYCLES)
    ) u_a12_filter (
        .m2       (m2),
        .reset_n  (reset_n),
        .ppu_a12  (ppu_a12),
        .clk_event(clk_event)
    );

    assign wr         = enable & ~romsel & ~cpu_rw_in & cpu_addr_in[14];
    assign sel        = irq_reg_e'({cpu_addr_in[13], cpu_addr_in[0]});
    assign wr_latch   = wr & (sel == REG_LATCH);
    assign wr_reload  = wr & (sel == REG_RELOAD);
    assign wr_disable = wr & (sel == REG_DISABLE);
    assign wr_enable  = wr & (sel == REG_ENABLE);
    assign evt        = clk_event & enable;

    // A $C001 write coinciding with a clock event behaves as a pending reload.
    assign reload_path = (counter_q == '0) | reload_q | wr_reload;
    assign next_cnt    = reload_path ? latch_q : counter_q - 1'b1;

    always_comb begin
        latch_d   = latch_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        irq_en_d  = irq_en_q;
        irq_d     = irq_q;
        hit       = 1'b0;

        if (wr_latch) latch_d = cpu_data_in;
        if (wr_reload) begin
            counter_d = '0;
            reload_d  = 1'b1;
        end
        if (evt) begin
            counter_d = next_cnt;
            if (reload_path) reload_d = 1'b0;
`ifdef COOLGIRL_MMC3_IRQ_REV_A_EN
            hit = (next_cnt == '0) & (~reload_path | reload_q | wr_reload);
`else
            hit = (next_cnt == '0);
`endif
        end

        if (wr_disable) irq_en_d = 1'b0;
        if (wr_enable)  irq_en_d = 1'b1;

        // irq_en_q (not irq_en_d) so a same-cycle $E001 cannot arm this hit.
        if (!enable || wr_disable) begin
            irq_d = 1'b1;
        end else if (hit && irq_en_q) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            latch_q   <= '0;
            counter_q <= '0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b1;
        end else begin
            latch_q   <= latch_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    assign irq         = irq_q;
    assign irq_counter = counter_q;

endmodule

// File: tb/tb_coolgirl_mmc3_irq.sv
// Self-checking bench for coolgirl_mmc3_irq (A12_LOW_CYCLES = 3).
module tb_coolgirl_mmc3_irq;

    logic        m2;
    logic        reset_n;
    logic        enable;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        ppu_a12;
    logic        irq;
    logic [7:0]  irq_counter;

    typedef struct {
        logic [7:0] cnt;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rev_a;

    coolgirl_mmc3_irq #(.A12_LOW_CYCLES(3)) dut (
        .m2         (m2),
        .reset_n    (reset_n),
        .enable     (enable),
        .romsel     (romsel),
        .cpu_rw_in  (cpu_rw_in),
        .cpu_addr_in(cpu_addr_in),
        .cpu_data_in(cpu_data_in),
        .ppu_a12    (ppu_a12),
        .irq        (irq),
        .irq_counter(irq_counter)
    );

    initial m2 = 1'b1;
    always #5 m2 = ~m2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(negedge m2);
        #1;
    endtask

    task automatic bus_set(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_in = a[14:0];
        cpu_data_in = d;
        romsel      = 1'b0;
        cpu_rw_in   = 1'b0;
    endtask

    task automatic bus_idle();
        romsel    = 1'b1;
        cpu_rw_in = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_set(a, d);
        tick();
        bus_idle();
    endtask

    // Filtered rise: long low phase, then high; counter updates on the 3rd
    // high edge. An optional write is placed on that same edge.
    task automatic rise(input bit with_wr, input logic [15:0] a, input logic [7:0] d);
        ppu_a12 = 1'b0;
        repeat (6) tick();
        ppu_a12 = 1'b1;
        tick();
        tick();
        if (with_wr) bus_set(a, d);
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_irq: got %b want 1", irq);
        end
        n_cmp++;
        if (irq_counter !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d want 0", irq_counter);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        wr(16'hC000, 8'd2);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        sb.push_back('{8'd2, 1'b1});
        sb.push_back('{8'd1, 1'b1});
        sb.push_back('{8'd0, 1'b0});
        sb.push_back('{8'd2, 1'b0});
        for (int i = 0; i < 4; i++) begin
            rise(1'b0, 16'h0, 8'h0);
            e = sb.pop_front();
            n_cmp++;
            if (irq_counter !== e.cnt) begin
                n_bad++;
                $display("FAIL basic_cnt rise%0d: got %0d want %0d", i, irq_counter, e.cnt);
            end
            n_cmp++;
            if (irq !== e.irq) begin
                n_bad++;
                $display("FAIL basic_irq rise%0d: got %b want %b", i, irq, e.irq);
            end
        end
        wr(16'hE000, 8'd0);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_e000_clear: got %b want 1", irq);
        end
    endtask

    task automatic test_short_low();
        for (int i = 0; i < 4; i++) begin
            ppu_a12 = 1'b0;
            tick();
            ppu_a12 = 1'b1;
            repeat (3) tick();
        end
        n_cmp++;
        if (irq_counter !== 8'd2) begin
            n_bad++;
            $display("FAIL short_low_cnt: got %0d want 2", irq_counter);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL short_low_irq: got %b want 1", irq);
        end
    endtask

    task automatic test_latch0();
        wr(16'hE000, 8'd0);
        wr(16'hC000, 8'd0);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{8'd0, (rev_a && i != 0) ? 1'b1 : 1'b0});
            rise(1'b0, 16'h0, 8'h0);
            e = sb.pop_front();
            n_cmp++;
            if (irq_counter !== e.cnt) begin
                n_bad++;
                $display("FAIL latch0_cnt rise%0d: got %0d want %0d", i, irq_counter, e.cnt);
            end
            n_cmp++;
            if (irq !== e.irq) begin
                n_bad++;
                $display("FAIL latch0_irq rise%0d: got %b want %b", i, irq, e.irq);
            end
            wr(16'hE000, 8'd0);
            wr(16'hE001, 8'd0);
        end
    endtask

    task automatic test_e000_hit();
        wr(16'hC000, 8'd1);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        sb.push_back('{8'd1, 1'b1});
        rise(1'b0, 16'h0, 8'h0);
        e = sb.pop_front();
        n_cmp++;
        if (irq_counter !== e.cnt) begin
            n_bad++;
            $display("FAIL e000hit_load_cnt: got %0d want %0d", irq_counter, e.cnt);
        end
        sb.push_back('{8'd0, 1'b1});
        rise(1'b1, 16'hE000, 8'h0);
        e = sb.pop_front();
        n_cmp++;
        if (irq_counter !== e.cnt) begin
            n_bad++;
            $display("FAIL e000hit_cnt: got %0d want %0d", irq_counter, e.cnt);
        end
        n_cmp++;
        if (irq !== e.irq) begin
            n_bad++;
            $display("FAIL e000hit_irq: got %b want %b", irq, e.irq);
        end
    endtask

    task automatic test_reset_mid();
        wr(16'hC000, 8'd1);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        rise(1'b0, 16'h0, 8'h0);
        rise(1'b0, 16'h0, 8'h0);
        wr(16'hC000, 8'd5);
        sb.push_back('{8'd5, 1'b0});
        rise(1'b0, 16'h0, 8'h0);
        e = sb.pop_front();
        n_cmp++;
        if (irq_counter !== e.cnt || irq !== e.irq) begin
            n_bad++;
            $display("FAIL resetmid_pre: got cnt %0d irq %b want cnt %0d irq %b",
                     irq_counter, irq, e.cnt, e.irq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL resetmid_irq: got %b want 1", irq);
        end
        n_cmp++;
        if (irq_counter !== 8'd0) begin
            n_bad++;
            $display("FAIL resetmid_cnt: got %0d want 0", irq_counter);
        end
        #1;
        reset_n = 1'b1;
        tick();
        wr(16'hC000, 8'd3);
        sb.push_back('{8'd3, 1'b1});
        rise(1'b0, 16'h0, 8'h0);
        e = sb.pop_front();
        n_cmp++;
        if (irq_counter !== e.cnt || irq !== e.irq) begin
            n_bad++;
            $display("FAIL resetmid_post: got cnt %0d irq %b want cnt %0d irq %b",
                     irq_counter, irq, e.cnt, e.irq);
        end
    endtask

    task automatic test_enable();
        wr(16'hC000, 8'd1);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        rise(1'b0, 16'h0, 8'h0);
        sb.push_back('{8'd0, 1'b0});
        rise(1'b0, 16'h0, 8'h0);
        e = sb.pop_front();
        n_cmp++;
        if (irq_counter !== e.cnt || irq !== e.irq) begin
            n_bad++;
            $display("FAIL enable_pre: got cnt %0d irq %b want cnt %0d irq %b",
                     irq_counter, irq, e.cnt, e.irq);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_off_irq: got %b want 1", irq);
        end
        wr(16'hC000, 8'd9);
        wr(16'hC001, 8'd0);
        wr(16'hE000, 8'd0);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{8'd0, 1'b1});
            rise(1'b0, 16'h0, 8'h0);
            e = sb.pop_front();
            n_cmp++;
            if (irq_counter !== e.cnt || irq !== e.irq) begin
                n_bad++;
                $display("FAIL enable_off_rise%0d: got cnt %0d irq %b want cnt %0d irq %b",
                         i, irq_counter, irq, e.cnt, e.irq);
            end
        end
        enable = 1'b1;
        sb.push_back('{8'd1, 1'b1});
        sb.push_back('{8'd0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            rise(1'b0, 16'h0, 8'h0);
            e = sb.pop_front();
            n_cmp++;
            if (irq_counter !== e.cnt || irq !== e.irq) begin
                n_bad++;
                $display("FAIL enable_on_rise%0d: got cnt %0d irq %b want cnt %0d irq %b",
                         i, irq_counter, irq, e.cnt, e.irq);
            end
        end
    endtask

    initial begin
`ifdef COOLGIRL_MMC3_IRQ_REV_A_EN
        rev_a = 1'b1;
`else
        rev_a = 1'b0;
`endif
        reset_n     = 1'b0;
        enable      = 1'b1;
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
        cpu_addr_in = '0;
        cpu_data_in = '0;
        ppu_a12     = 1'b0;

        test_reset();
        test_basic();
        test_short_low();
        test_latch0();
        test_e000_hit();
        test_reset_mid();
        test_enable();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
